// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the IF stage.
// Drives the instruction-memory fetch address (pc) and chip enable (ce).
// It supports a reset vector, stall and imem-ready gating, and branch/jump
// redirects. A branch that arrives while the fetch cannot advance is parked
// in a pending buffer. Exception redirects take effect immediately.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : a br_target with [1:0]!=0 is rejected, and misalign pulses for one cycle.
//   undefined : the low two target bits are forced to 0 on load, and misalign stays 0.
//
// Ports
//   clk, rst     clock (rising edge); synchronous active-high reset
//   stall        hazard-unit stall; holds pc
//   if_ready     imem accepts the current pc this cycle
//   br_valid     branch/jump taken this cycle, with target br_target
//   exc_valid    exception/eret redirect this cycle, with target exc_target
//   pc, ce       fetch address and fetch request valid
//   redir_taken  1-cycle pulse: a redirect was loaded into pc
//   misalign     1-cycle pulse: a misaligned br_target was rejected
module pc_gen #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       INC       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              if_ready,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              redir_taken,
  output logic              misalign
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] INC_V     = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic              redir_q, redir_d;
  logic              misalign_q, misalign_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  logic              adv;
  logic              br_bad;
  logic              br_ok;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] exc_tgt;

  // Fetch advances only when a request is out, imem takes it, and nothing stalls.
  assign adv = ce_q & ~stall & if_ready;

  // Target conditioning: either reject misaligned branches or force word alignment.
`ifdef PC_ALIGN_CHECK_EN
  assign br_bad  = br_valid & (br_target[1:0] != 2'b00);
  assign br_tgt  = br_target;
  assign exc_tgt = exc_target;
`else
  assign br_bad  = 1'b0;
  assign br_tgt  = br_target & WORD_MASK;
  assign exc_tgt = exc_target & WORD_MASK;
`endif

  assign br_ok = br_valid & ~br_bad;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ce_d       = ce_q;
    redir_d    = 1'b0;
    misalign_d = 1'b0;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;

    unique case (state_q)
      S_RST: begin
        // The first edge after reset only raises ce. RESET_VEC is the first fetch.
        ce_d    = 1'b1;
        state_d = S_RUN;
      end

      S_RUN: begin
        misalign_d = br_bad & ~exc_valid;
        if (exc_valid) begin
          pc_d     = exc_tgt;
          pend_v_d = 1'b0;
          redir_d  = 1'b1;
        end else if (br_ok && adv) begin
          pc_d    = br_tgt;
          redir_d = 1'b1;
        end else if (br_ok) begin
          // The fetch cannot move this cycle. Park the target until it can.
          pend_tgt_d = br_tgt;
          pend_v_d   = 1'b1;
          state_d    = S_HOLD;
        end else if (adv) begin
          pc_d = pc_q + INC_V;
        end
      end

      S_HOLD: begin
        misalign_d = br_bad & ~exc_valid;
        if (exc_valid) begin
          // An exception flushes the parked branch.
          pc_d     = exc_tgt;
          pend_v_d = 1'b0;
          redir_d  = 1'b1;
          state_d  = S_RUN;
        end else if (adv && (pend_v_q || br_ok)) begin
          // The newest branch wins over the parked one.
          pc_d     = br_ok ? br_tgt : pend_tgt_q;
          pend_v_d = 1'b0;
          redir_d  = 1'b1;
          state_d  = S_RUN;
        end else if (adv) begin
          pc_d    = pc_q + INC_V;
          state_d = S_RUN;
        end else if (br_ok) begin
          pend_tgt_d = br_tgt;
        end
      end

      default: begin
        state_d = S_RST;
      end
    endcase
  end

  // State and output registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      pc_q       <= RESET_VEC;
      ce_q       <= 1'b0;
      redir_q    <= 1'b0;
      misalign_q <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      redir_q    <= redir_d;
      misalign_q <= misalign_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc          = pc_q;
  assign ce          = ce_q;
  assign redir_taken = redir_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen (default parameters).
// A reference model predicts the outputs for each driven cycle. The prediction
// is queued and then compared once the DUT has taken the clock edge.
module tb_pc_gen;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam logic [31:0] INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic        redir;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        if_ready = 1'b1;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_target = '0;
  logic [31:0] pc;
  logic        ce;
  logic        redir_taken;
  logic        misalign;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";

  // Reference model state.
  logic [31:0] m_pc = '0;
  logic [31:0] m_pend = '0;
  logic        m_ce = 1'b0;
  logic        m_redir = 1'b0;
  logic        m_mis = 1'b0;
  logic        m_hold = 1'b0;
  logic        m_started = 1'b0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .if_ready   (if_ready),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .exc_valid  (exc_valid),
    .exc_target (exc_target),
    .pc         (pc),
    .ce         (ce),
    .redir_taken(redir_taken),
    .misalign   (misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s_%s: got %h expected %h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge, using the currently driven inputs.
  task automatic model_step();
    logic adv;
    logic bad;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_ce = 1'b0; m_redir = 1'b0; m_mis = 1'b0;
      m_hold = 1'b0; m_started = 1'b0;
    end else if (!m_started) begin
      m_started = 1'b1; m_ce = 1'b1; m_redir = 1'b0; m_mis = 1'b0;
    end else begin
      adv = !stall && if_ready;
      bad = ALIGN && (br_target[1:0] != 2'b00);
      tgt = ALIGN ? br_target : (br_target & ~32'h3);
      m_redir = 1'b0;
      m_mis = 1'b0;
      if (exc_valid) begin
        m_pc = ALIGN ? exc_target : (exc_target & ~32'h3);
        m_hold = 1'b0;
        m_redir = 1'b1;
      end else begin
        if (br_valid && bad) m_mis = 1'b1;
        if (br_valid && !bad) begin
          m_pend = tgt;
          m_hold = 1'b1;
        end
        if (adv) begin
          if (m_hold) begin
            m_pc = m_pend;
            m_hold = 1'b0;
            m_redir = 1'b1;
          end else begin
            m_pc = m_pc + INC;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rdy, input logic bv,
                      input logic [31:0] bt, input logic ev, input logic [31:0] et);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; if_ready = rdy;
    br_valid = bv; br_target = bt; exc_valid = ev; exc_target = et;
    model_step();
    e.pc = m_pc; e.ce = m_ce; e.redir = m_redir; e.mis = m_mis;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("pc", pc, e.pc);
      check("ce", 32'(ce), 32'(e.ce));
      check("redir", 32'(redir_taken), 32'(e.redir));
      check("mis", 32'(misalign), 32'(e.mis));
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // T1: reset, then sequential fetch from the reset vector.
    phase = "t1";
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_ce", 32'(ce), 32'd0);
    check("rst_pc", pc, 32'h0);
    idle();
    check("first_ce", 32'(ce), 32'd1);
    check("first_pc", pc, 32'h0);
    repeat (3) idle();
    check("pc_c", pc, 32'hC);
    idle();

    // T2: stall holds pc.
    phase = "t2";
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("hold", pc, 32'h10);
    idle();
    check("resume", pc, 32'h14);
    repeat (3) idle();

    // T3: branch taken with no stall.
    phase = "t3";
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    check("br_pc", pc, 32'h100);
    check("br_redir", 32'(redir_taken), 32'd1);
    idle();
    check("after_pc", pc, 32'h104);
    check("after_redir", 32'(redir_taken), 32'd0);

    // T4: the newest branch wins while stalled.
    phase = "t4";
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    check("held", pc, 32'h104);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    idle();
    check("newest", pc, 32'h300);
    idle();

    // T5: an exception under stall flushes the pending branch.
    phase = "t5";
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h180);
    check("exc", pc, 32'h180);
    idle();
    check("dropped", pc, 32'h184);

    // A branch during ~if_ready waits for the handshake.
    phase = "rdy";
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    check("pend_load", pc, 32'h400);

    // T6: wrap at the top of the address space, then a misaligned branch.
    phase = "t6";
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    idle();
    check("wrap", pc, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h102, 1'b0, 32'h0);
    check("mis_pc", pc, ALIGN ? 32'h4 : 32'h100);
    check("mis_flag", 32'(misalign), 32'(ALIGN));
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1F3);
    idle();

    // Reset in the middle of operation discards a pending branch.
    phase = "midrst";
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("pc0", pc, 32'h0);
    idle();
    idle();
    check("no_pend", pc, 32'h4);

    // Random traffic.
    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           $urandom(),
           ($urandom_range(0, 11) == 0),
           $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
